apb_req_arbiter: RTL and testbench

//  Shares one APB master among NUM_REQ requesters using round-robin arbitration.

---
 rtl/apb_req_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin front end that shares one APB master among NUM_REQ
// requesters, latches the winner's command and returns completion status to it.
module apb_req_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                        pclk,
   input  logic                        preset,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ-1:0]          req_write,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]          gnt,
   output logic [NUM_REQ-1:0]          done,
   output logic                        rsp_err,
   output logic                        rsp_timeout,
   output logic [DATA_W-1:0]           rsp_rdata,
   output logic                        busy,
   output logic                        m_transfer,
   output logic                        m_read,
   output logic                        m_write,
   output logic [ADDR_W-1:0]           m_write_paddr,
   output logic [ADDR_W-1:0]           m_read_paddr,
   output logic [DATA_W-1:0]           m_write_data,
   input  logic                        m_psel,
   input  logic                        m_penable,
   input  logic                        m_pready,
   input  logic                        m_pslverr,
   input  logic [DATA_W-1:0]           m_read_data
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [IDX_W-1:0]    idx, idx_nxt;
   logic [IDX_W-1:0]    ptr, ptr_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;

   logic [NUM_REQ-1:0]  gnt_nxt;
   logic [NUM_REQ-1:0]  done_nxt;
   logic                rsp_err_nxt;
   logic                rsp_timeout_nxt;
   logic [DATA_W-1:0]   rsp_rdata_nxt;
   logic                busy_nxt;
   logic                m_transfer_nxt;
   logic                m_read_nxt;
   logic                m_write_nxt;
   logic [ADDR_W-1:0]   m_write_paddr_nxt;
   logic [ADDR_W-1:0]   m_read_paddr_nxt;
   logic [DATA_W-1:0]   m_write_data_nxt;

   logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
   logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

   logic                win_found;
   logic [IDX_W-1:0]    win_idx;
   logic [IDX_W-1:0]    cand;
   logic                xfer_ok_c;
   logic                tmo_hit_c;

   // Split the packed per-requester command buses into arrays.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
      assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
   end

   // Rotating priority: first requester at or after ptr+1, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign xfer_ok_c = m_psel & m_penable & m_pready;
   assign tmo_hit_c = (cnt == CNT_W'(TIMEOUT - 1));

   // Next-state and registered-output logic.
   always_comb begin
      state_nxt         = state;
      idx_nxt           = idx;
      ptr_nxt           = ptr;
      cnt_nxt           = cnt;
      gnt_nxt           = gnt;
      done_nxt          = '0;
      rsp_err_nxt       = 1'b0;
      rsp_timeout_nxt   = 1'b0;
      rsp_rdata_nxt     = rsp_rdata;
      busy_nxt          = busy;
      m_transfer_nxt    = m_transfer;
      m_read_nxt        = m_read;
      m_write_nxt       = m_write;
      m_write_paddr_nxt = m_write_paddr;
      m_read_paddr_nxt  = m_read_paddr;
      m_write_data_nxt  = m_write_data;

      case (state)
         ST_IDLE: begin
            if (win_found) begin
               state_nxt         = ST_XFER;
               idx_nxt           = win_idx;
               gnt_nxt           = NUM_REQ'(1) << win_idx;
               busy_nxt          = 1'b1;
               m_transfer_nxt    = 1'b1;
               m_write_nxt       = req_write[win_idx];
               m_read_nxt        = ~req_write[win_idx];
               m_write_paddr_nxt = addr_arr[win_idx];
               m_read_paddr_nxt  = addr_arr[win_idx];
               m_write_data_nxt  = wdata_arr[win_idx];
               cnt_nxt           = '0;
            end
         end

         ST_XFER: begin
            cnt_nxt = cnt + CNT_W'(1);
            // A real handshake beats a timeout landing on the same edge.
            if (xfer_ok_c || tmo_hit_c) begin
               state_nxt       = ST_DONE;
               done_nxt        = NUM_REQ'(1) << idx;
               rsp_err_nxt     = xfer_ok_c ? m_pslverr : 1'b1;
               rsp_timeout_nxt = ~xfer_ok_c;
               if (xfer_ok_c && !m_write) begin
                  rsp_rdata_nxt = m_read_data;
               end
               gnt_nxt         = '0;
               m_transfer_nxt  = 1'b0;
               m_read_nxt      = 1'b0;
               m_write_nxt     = 1'b0;
               ptr_nxt         = idx;
               cnt_nxt         = '0;
            end
         end

         ST_DONE: begin
            // One dead cycle lets the master fall back to its own idle.
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge pclk) begin
      if (preset) begin
         state         <= ST_IDLE;
         idx           <= '0;
         ptr           <= IDX_W'(NUM_REQ - 1);
         cnt           <= '0;
         gnt           <= '0;
         done          <= '0;
         rsp_err       <= 1'b0;
         rsp_timeout   <= 1'b0;
         rsp_rdata     <= '0;
         busy          <= 1'b0;
         m_transfer    <= 1'b0;
         m_read        <= 1'b0;
         m_write       <= 1'b0;
         m_write_paddr <= '0;
         m_read_paddr  <= '0;
         m_write_data  <= '0;
      end else begin
         state         <= state_nxt;
         idx           <= idx_nxt;
         ptr           <= ptr_nxt;
         cnt           <= cnt_nxt;
         gnt           <= gnt_nxt;
         done          <= done_nxt;
         rsp_err       <= rsp_err_nxt;
         rsp_timeout   <= rsp_timeout_nxt;
         rsp_rdata     <= rsp_rdata_nxt;
         busy          <= busy_nxt;
         m_transfer    <= m_transfer_nxt;
         m_read        <= m_read_nxt;
         m_write       <= m_write_nxt;
         m_write_paddr <= m_write_paddr_nxt;
         m_read_paddr  <= m_read_paddr_nxt;
         m_write_data  <= m_write_data_nxt;
      end
   end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed and randomized transactions checked against a
// transaction-level round-robin model; the bench plays the APB master/slave side.
module tb_apb_req_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 8;
   localparam int TIMEOUT = 8;
   localparam int AW_ALL  = NUM_REQ * ADDR_W;
   localparam int DW_ALL  = NUM_REQ * DATA_W;

   logic                 pclk;
   logic                 preset;
   logic [NUM_REQ-1:0]   req;
   logic [NUM_REQ-1:0]   req_write;
   logic [AW_ALL-1:0]    req_addr;
   logic [DW_ALL-1:0]    req_wdata;
   logic [NUM_REQ-1:0]   gnt;
   logic [NUM_REQ-1:0]   done;
   logic                 rsp_err;
   logic                 rsp_timeout;
   logic [DATA_W-1:0]    rsp_rdata;
   logic                 busy;
   logic                 m_transfer;
   logic                 m_read;
   logic                 m_write;
   logic [ADDR_W-1:0]    m_write_paddr;
   logic [ADDR_W-1:0]    m_read_paddr;
   logic [DATA_W-1:0]    m_write_data;
   logic                 m_psel;
   logic                 m_penable;
   logic                 m_pready;
   logic                 m_pslverr;
   logic [DATA_W-1:0]    m_read_data;

   int                   checks = 0;
   int                   errs   = 0;
   int                   ref_ptr;
   logic [DATA_W-1:0]    ref_rdata;

   apb_req_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .pclk          (pclk),
      .preset        (preset),
      .req           (req),
      .req_write     (req_write),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .gnt           (gnt),
      .done          (done),
      .rsp_err       (rsp_err),
      .rsp_timeout   (rsp_timeout),
      .rsp_rdata     (rsp_rdata),
      .busy          (busy),
      .m_transfer    (m_transfer),
      .m_read        (m_read),
      .m_write       (m_write),
      .m_write_paddr (m_write_paddr),
      .m_read_paddr  (m_read_paddr),
      .m_write_data  (m_write_data),
      .m_psel        (m_psel),
      .m_penable     (m_penable),
      .m_pready      (m_pready),
      .m_pslverr     (m_pslverr),
      .m_read_data   (m_read_data)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Round robin: lowest requester above the last winner, else lowest overall.
   function automatic int pick(input logic [NUM_REQ-1:0] r, input int p);
      for (int i = p + 1; i < NUM_REQ; i++)
         if (((r >> i) & NUM_REQ'(1)) != '0) return i;
      for (int i = 0; i < NUM_REQ; i++)
         if (((r >> i) & NUM_REQ'(1)) != '0) return i;
      return -1;
   endfunction

   task automatic set_cmd(input int i, input bit wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
      req_write = (req_write & ~(NUM_REQ'(1) << i)) | (NUM_REQ'(wr) << i);
      req_addr  = (req_addr & ~(AW_ALL'({ADDR_W{1'b1}}) << (i*ADDR_W))) | (AW_ALL'(a) << (i*ADDR_W));
      req_wdata = (req_wdata & ~(DW_ALL'({DATA_W{1'b1}}) << (i*DATA_W))) | (DW_ALL'(d) << (i*DATA_W));
   endtask

   task automatic do_reset(input logic [NUM_REQ-1:0] hold_req);
      @(negedge pclk);
      preset    = 1'b1;
      req       = hold_req;
      m_psel    = 1'b0;
      m_penable = 1'b0;
      m_pready  = 1'b0;
      @(posedge pclk);
      @(negedge pclk);
      chk("rst_gnt",   32'(gnt), 0);
      chk("rst_done",  32'(done), 0);
      chk("rst_xfer",  32'(m_transfer), 0);
      chk("rst_busy",  32'(busy), 0);
      chk("rst_err",   32'(rsp_err), 0);
      chk("rst_tmo",   32'(rsp_timeout), 0);
      chk("rst_rdata", 32'(rsp_rdata), 0);
      chk("rst_rw",    32'({m_read, m_write}), 0);
      chk("rst_addr",  32'({m_write_paddr, m_read_paddr, m_write_data}), 0);
      preset    = 1'b0;
      ref_ptr   = NUM_REQ - 1;
      ref_rdata = '0;
   endtask

   // Entered at a negedge with the DUT idle and req nonzero; leaves at the
   // negedge after DONE with req = next_req applied during DONE.
   task automatic do_txn(input bit to_mode, input int k, input bit err,
                         input logic [DATA_W-1:0] rdata, input logic [NUM_REQ-1:0] next_req);
      int                w;
      bit                wr;
      bit                fin;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      w  = pick(req, ref_ptr);
      wr = ((req_write >> w) & NUM_REQ'(1)) != '0;
      a  = ADDR_W'(req_addr >> (w*ADDR_W));
      d  = DATA_W'(req_wdata >> (w*DATA_W));
      @(posedge pclk);
      @(negedge pclk);
      chk("gnt",   32'(gnt), 32'(1 << w));
      chk("xfer",  32'(m_transfer), 1);
      chk("busy",  32'(busy), 1);
      chk("wr",    32'(m_write), 32'(wr));
      chk("rd",    32'(m_read), 32'(!wr));
      chk("waddr", 32'(m_write_paddr), 32'(a));
      chk("raddr", 32'(m_read_paddr), 32'(a));
      chk("wdata", 32'(m_write_data), 32'(d));
      req       = NUM_REQ'($urandom);
      req_write = NUM_REQ'($urandom);
      req_addr  = AW_ALL'($urandom);
      req_wdata = DW_ALL'($urandom);
      for (int c = 0; c < TIMEOUT; c++) begin
         fin         = (!to_mode && c == k - 1) || (c == TIMEOUT - 1);
         m_psel      = 1'b1;
         m_penable   = (c > 0);
         m_pready    = (c == 0) ? 1'($urandom_range(0, 1)) : (!to_mode && c == k - 1);
         m_pslverr   = (!to_mode && c == k - 1) ? err : 1'($urandom_range(0, 1));
         m_read_data = (!to_mode && c == k - 1) ? rdata : DATA_W'($urandom);
         @(posedge pclk);
         @(negedge pclk);
         if (fin) break;
         chk("hold_done", 32'(done), 0);
         chk("hold_gnt",  32'(gnt), 32'(1 << w));
         chk("hold_cmd",  32'({m_transfer, m_write, m_write_paddr, m_write_data}),
                          32'({1'b1, wr, a, d}));
      end
      if (!to_mode && !wr) ref_rdata = rdata;
      chk("done",    32'(done), 32'(1 << w));
      chk("err",     32'(rsp_err), to_mode ? 1 : 32'(err));
      chk("tmo",     32'(rsp_timeout), 32'(to_mode));
      chk("rdata",   32'(rsp_rdata), 32'(ref_rdata));
      chk("end_gnt", 32'(gnt), 0);
      chk("end_xfer",32'(m_transfer), 0);
      chk("end_busy",32'(busy), 1);
      ref_ptr   = w;
      m_psel    = 1'b0;
      m_penable = 1'b0;
      m_pready  = 1'b0;
      req       = next_req;
      @(posedge pclk);
      @(negedge pclk);
      chk("idle_gnt",  32'(gnt), 0);
      chk("idle_done", 32'({done, rsp_err, rsp_timeout}), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_rdat", 32'(rsp_rdata), 32'(ref_rdata));
   endtask

   initial begin
      preset      = 1'b1;
      req         = '0;
      req_write   = '0;
      req_addr    = '0;
      req_wdata   = '0;
      m_psel      = 1'b0;
      m_penable   = 1'b0;
      m_pready    = 1'b0;
      m_pslverr   = 1'b0;
      m_read_data = '0;

      // Single write from requester 1, pready on the second access cycle.
      do_reset('0);
      set_cmd(1, 1'b1, 8'h3C, 8'hA5);
      req = 4'b0010;
      do_txn(1'b0, 3, 1'b0, DATA_W'($urandom), '0);

      // All requesters held high after reset: order 0,1,2,3,0.
      do_reset(4'b1111);
      for (int n = 0; n < 5; n++) begin
         req_write = NUM_REQ'($urandom);
         req_addr  = AW_ALL'($urandom);
         req_wdata = DW_ALL'($urandom);
         req       = 4'b1111;
         do_txn(1'b0, $urandom_range(2, TIMEOUT), 1'b0, DATA_W'($urandom), 4'b1111);
      end

      // Read from requester 2.
      req = '0;
      set_cmd(2, 1'b0, 8'h10, 8'h00);
      req = 4'b0100;
      do_txn(1'b0, 2, 1'b0, 8'h5E, '0);

      // Slave error, then the pointer must have moved past requester 0.
      set_cmd(0, 1'b1, 8'h77, 8'h11);
      req = 4'b0001;
      do_txn(1'b0, 2, 1'b1, DATA_W'($urandom), 4'b1111);
      do_txn(1'b0, 2, 1'b0, DATA_W'($urandom), '0);

      // Stalled slave: timeout after TIMEOUT cycles.
      set_cmd(3, 1'b0, 8'h20, 8'h00);
      req = 4'b1000;
      do_txn(1'b1, 0, 1'b0, DATA_W'($urandom), '0);

      // Completion on the timeout edge: completion wins.
      set_cmd(1, 1'b0, 8'h40, 8'h00);
      req = 4'b0010;
      do_txn(1'b0, TIMEOUT, 1'b0, 8'hC3, '0);

      // Reset mid-transfer with requester 3 still asserting.
      set_cmd(3, 1'b1, 8'h99, 8'h66);
      req = 4'b1000;
      @(posedge pclk);
      @(negedge pclk);
      chk("pre_rst_gnt", 32'(gnt), 32'h8);
      m_psel = 1'b1;
      do_reset(4'b1000);
      do_txn(1'b0, 2, 1'b0, DATA_W'($urandom), '0);
      do_reset(4'b1001);
      do_txn(1'b0, 2, 1'b0, DATA_W'($urandom), '0);

      // Randomized traffic.
      for (int n = 0; n < 60; n++) begin
         if (req == '0) begin
            @(posedge pclk);
            @(negedge pclk);
            chk("nogrant", 32'({gnt, busy, m_transfer}), 0);
            req = NUM_REQ'(1) << $urandom_range(0, NUM_REQ - 1);
         end
         req_write = NUM_REQ'($urandom);
         req_addr  = AW_ALL'($urandom);
         req_wdata = DW_ALL'($urandom);
         do_txn(($urandom_range(0, 5) == 0), $urandom_range(2, TIMEOUT),
                1'($urandom_range(0, 1)), DATA_W'($urandom), NUM_REQ'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
